echo_timer: RTL and testbench
=============================

ECHO_TIMER -- requirements
Module: echo_timer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16'd40000, meaning the maximum cycles spent in ARM or MEAS before abort (legal 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: level enable, synchronous to clk; 0 aborts any measurement.
REQ-005 The block SHALL have port trig_in, input, 1 bit: trigger pulse train from the upstream timing generator, synchronous to clk.
REQ-006 The block SHALL have port echo, input, 1 bit: asynchronous sensor echo level.
REQ-007 The block SHALL have port width, output, 16 bits: last measured echo-high duration in clk cycles.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when width is updated.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a measurement is abandoned on TIMEOUT.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 echo SHALL pass through a 2-flop synchronizer; echo_s (second flop) is the only echo signal used by the FSM.
REQ-012 trig_in SHALL be registered once (trig_d); a trigger edge is trig_in=1 and trig_d=0 in the same cycle.
REQ-013 The FSM SHALL have states IDLE, ARM, MEAS; a 16-bit counter cnt serves both timed states.
REQ-014 IDLE: start=1 and trigger edge -> ARM with cnt<=0; otherwise remain IDLE.
REQ-015 ARM: cnt increments each cycle; echo_s=1 -> MEAS with cnt<=1; else cnt==TIMEOUT-1 -> IDLE with timeout pulse.
REQ-016 MEAS: echo_s=1 and cnt<TIMEOUT -> cnt<=cnt+1; echo_s=0 -> width<=cnt, valid<=1, IDLE.
REQ-017 MEAS: echo_s=1 and cnt==TIMEOUT -> IDLE, timeout pulse, width unchanged, no valid.
REQ-018 width SHALL therefore equal the number of consecutive cycles echo_s was sampled high (1..TIMEOUT).
REQ-019 valid SHALL rise on the clock edge after the first echo_s=0 sample in MEAS, i.e. 3 cycles after echo falls at the pin.
REQ-020 valid and timeout SHALL never be high together and SHALL each be high for exactly one cycle per event.
REQ-021 start=0 in ARM or MEAS SHALL force IDLE on the next edge, cnt<=0, no valid, no timeout, width unchanged; start has priority over all other transitions.
REQ-022 Trigger edges in ARM or MEAS SHALL be ignored (no restart).
REQ-023 echo already high when ARM is entered SHALL transition to MEAS on the first ARM cycle (measurement counts from that point).
REQ-024 width SHALL hold its value across any number of idle, aborted or timed-out cycles until the next valid.

Reset
REQ-025 clr=0 SHALL immediately force state IDLE, cnt=0, width=0, valid=0, timeout=0, busy=0, synchronizer and trig_d flops to 0.
REQ-026 Deassertion of clr SHALL take effect on the next clock edge; no event SHALL be produced from pre-reset history.
REQ-027 Reset asserted mid-MEAS SHALL discard the measurement with no valid pulse.

Verification
REQ-028 Reset then start=1, trigger pulse, echo high 200 cycles after 10-cycle delay -> valid one cycle, width=200, busy low next cycle.
REQ-029 TIMEOUT=100, trigger with echo never high -> timeout pulse exactly 100 cycles after ARM entry, width stays 0, no valid.
REQ-030 TIMEOUT=100, echo held high 500 cycles -> timeout pulse when cnt reaches 100 in MEAS, no valid, width unchanged.
REQ-031 start dropped 20 cycles into MEAS -> IDLE next edge, no valid/timeout; subsequent trigger with echo high 50 cycles -> width=50.
REQ-032 Second trigger pulse during MEAS (echo high 300 cycles) -> ignored, single valid with width=300.
REQ-033 clr pulled low mid-MEAS -> all outputs 0 asynchronously, no valid after release until a new trigger.

Source files
------------

// File: rtl/echo_timer.sv
// echo_timer: measures the high duration of a synchronized echo after a trigger edge,
// aborting on start=0 or after TIMEOUT cycles in ARM or MEAS.
module echo_timer #(
    parameter logic [15:0] TIMEOUT = 16'd40000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        trig_in,
    input  logic        echo,
    output logic [15:0] width,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, width_q, width_d;
    logic        valid_q, valid_d, timeout_q, timeout_d;
    logic        echo_m_q, echo_s_q, trig_d_q;
    logic        trig_edge;
    assign trig_edge = trig_in & ~trig_d_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && trig_edge) begin
                    state_d = ARM;
                    cnt_d   = 16'd0;
                end
            end
            ARM: begin
                if (!start) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (echo_s_q) begin
                    state_d = MEAS;
                    cnt_d   = 16'd1;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MEAS: begin
                if (!start) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (!echo_s_q) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    width_d = cnt_q;
                    valid_d = 1'b1;
                end else if (cnt_q >= TIMEOUT) begin
                    state_d   = IDLE;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            width_q   <= 16'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            echo_m_q  <= 1'b0;
            echo_s_q  <= 1'b0;
            trig_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            echo_m_q  <= echo;
            echo_s_q  <= echo_m_q;
            trig_d_q  <= trig_in;
        end
    end
    assign width   = width_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_echo_timer.sv
// tb_echo_timer: scoreboard bench driving a default-TIMEOUT and a TIMEOUT=100 instance in parallel.
module tb_echo_timer;
    logic        clk = 1'b0, clr = 1'b0, start = 1'b0, trig_in = 1'b0, echo = 1'b0;
    logic [15:0] width_a, width_b;
    logic        valid_a, valid_b, timeout_a, timeout_b, busy_a, busy_b;
    int          n_checks = 0, n_fail = 0;
    logic [16:0] q_a[$], q_b[$];
    logic [16:0] e_a, e_b;
    logic [15:0] mw_a = 16'd0, mw_b = 16'd0;

    echo_timer dut_a (
        .clk(clk), .clr(clr), .start(start), .trig_in(trig_in), .echo(echo),
        .width(width_a), .valid(valid_a), .timeout(timeout_a), .busy(busy_a)
    );
    echo_timer #(.TIMEOUT(16'd100)) dut_b (
        .clk(clk), .clr(clr), .start(start), .trig_in(trig_in), .echo(echo),
        .width(width_b), .valid(valid_b), .timeout(timeout_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got running, required finished");
        $fatal(1);
    end

    // Each event pops the next expected {timeout, width}; a timeout expects width unchanged.
    always @(negedge clk) begin
        if (valid_a || timeout_a) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL event_a: unexpected valid=%0b timeout=%0b width=%0d, required no event", valid_a, timeout_a, width_a);
            end else begin
                e_a = q_a.pop_front();
                if (({timeout_a, width_a} !== e_a) || (valid_a && timeout_a)) begin
                    n_fail++;
                    $display("FAIL event_a: got valid=%0b timeout=%0b width=%0d, required timeout=%0b width=%0d", valid_a, timeout_a, width_a, e_a[16], e_a[15:0]);
                end
            end
        end
        if (valid_b || timeout_b) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL event_b: unexpected valid=%0b timeout=%0b width=%0d, required no event", valid_b, timeout_b, width_b);
            end else begin
                e_b = q_b.pop_front();
                if (({timeout_b, width_b} !== e_b) || (valid_b && timeout_b)) begin
                    n_fail++;
                    $display("FAIL event_b: got valid=%0b timeout=%0b width=%0d, required timeout=%0b width=%0d", valid_b, timeout_b, width_b, e_b[16], e_b[15:0]);
                end
            end
        end
    end

    task automatic push_ev(input bit on_b, input bit to, input logic [15:0] w);
        if (on_b) begin
            if (!to) mw_b = w;
            q_b.push_back({to, mw_b});
        end else begin
            if (!to) mw_a = w;
            q_a.push_back({to, mw_a});
        end
    endtask

    task automatic trigger();
        @(posedge clk); #1 trig_in = 1'b1;
        @(posedge clk); #1 trig_in = 1'b0;
    endtask

    task automatic hold_echo(input int delay, input int n);
        repeat (delay) @(posedge clk);
        #1 echo = 1'b1;
        repeat (n) @(posedge clk);
        #1 echo = 1'b0;
    endtask

    task automatic settle(input string name);
        int c = 0;
        while ((busy_a || busy_b || q_a.size() != 0 || q_b.size() != 0) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= 2000) begin
            n_fail++;
            $display("FAIL %s_settle: busy_a=%0b busy_b=%0b pending=%0d/%0d, required idle and no pending", name, busy_a, busy_b, q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({width_a, valid_a, timeout_a, busy_a, width_b, valid_b, timeout_b, busy_b} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: width_a=%0d busy_a=%0b width_b=%0d busy_b=%0b, required all 0", width_a, busy_a, width_b, busy_b);
        end
        @(posedge clk); #3 clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || valid_a !== 1'b0 || timeout_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy_a=%0b busy_b=%0b valid_a=%0b timeout_a=%0b, required 0", busy_a, busy_b, valid_a, timeout_a);
        end
    endtask

    task automatic test_basic();
        int cyc = 0;
        trigger();
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy_a=%0b, required 1", busy_a);
        end
        push_ev(1'b0, 1'b0, 16'd200);
        push_ev(1'b1, 1'b1, 16'd0);
        hold_echo(10, 200);
        while (cyc < 10) begin
            @(posedge clk);
            cyc++;
            #1;
            if (valid_a) break;
        end
        n_checks++;
        if (cyc !== 3 || valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: valid after %0d cycles, required 3", cyc);
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_low: busy_a=%0b, required 0", busy_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (valid_a !== 1'b0 || width_a !== 16'd200) begin
            n_fail++;
            $display("FAIL basic_pulse: valid_a=%0b width_a=%0d, required valid 0 width 200", valid_a, width_a);
        end
        settle("basic");
    endtask

    task automatic test_arm_timeout();
        int cyc = 0;
        trigger();
        push_ev(1'b1, 1'b1, 16'd0);
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (timeout_b) break;
        end
        n_checks++;
        if (cyc !== 100) begin
            n_fail++;
            $display("FAIL arm_timeout_time: timeout after %0d cycles, required 100", cyc);
        end
        n_checks++;
        if (width_b !== 16'd0 || valid_b !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_timeout_state: width_b=%0d valid_b=%0b busy_a=%0b, required 0 0 1", width_b, valid_b, busy_a);
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy_a !== 1'b0 || width_a !== 16'd200) begin
            n_fail++;
            $display("FAIL arm_abort: busy_a=%0b width_a=%0d, required 0 200", busy_a, width_a);
        end
        start = 1'b1;
        settle("arm_timeout");
    endtask

    task automatic test_meas_timeout();
        trigger();
        push_ev(1'b1, 1'b1, 16'd0);
        push_ev(1'b0, 1'b0, 16'd500);
        hold_echo(4, 500);
        settle("meas_timeout");
        n_checks++;
        if (width_b !== 16'd0 || width_a !== 16'd500) begin
            n_fail++;
            $display("FAIL meas_timeout_width: width_b=%0d width_a=%0d, required 0 500", width_b, width_a);
        end
    endtask

    task automatic test_abort();
        trigger();
        repeat (5) @(posedge clk);
        #1 echo = 1'b1;
        repeat (22) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy_a=%0b busy_b=%0b, required 0", busy_a, busy_b);
        end
        echo = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        n_checks++;
        if (width_a !== 16'd500 || width_b !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_width: width_a=%0d width_b=%0d, required 500 0", width_a, width_b);
        end
        trigger();
        push_ev(1'b0, 1'b0, 16'd50);
        push_ev(1'b1, 1'b0, 16'd50);
        hold_echo(6, 50);
        settle("abort");
    endtask

    task automatic test_back_to_back();
        trigger();
        push_ev(1'b0, 1'b0, 16'd300);
        push_ev(1'b1, 1'b1, 16'd0);
        repeat (3) @(posedge clk);
        #1 echo = 1'b1;
        repeat (50) @(posedge clk);
        trigger();
        repeat (248) @(posedge clk);
        #1 echo = 1'b0;
        settle("back_to_back");
        n_checks++;
        if (width_a !== 16'd300 || width_b !== 16'd50) begin
            n_fail++;
            $display("FAIL back_to_back_width: width_a=%0d width_b=%0d, required 300 50", width_a, width_b);
        end
    endtask

    task automatic test_reset_mid();
        trigger();
        repeat (5) @(posedge clk);
        #1 echo = 1'b1;
        repeat (30) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        n_checks++;
        if ({width_a, valid_a, timeout_a, busy_a, width_b, valid_b, timeout_b, busy_b} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: width_a=%0d busy_a=%0b width_b=%0d busy_b=%0b, required all 0", width_a, busy_a, width_b, busy_b);
        end
        mw_a = 16'd0;
        mw_b = 16'd0;
        @(posedge clk); #3 clr = 1'b1;
        repeat (20) @(posedge clk);
        #1 echo = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || width_a !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: busy_a=%0b busy_b=%0b width_a=%0d, required 0 0 0", busy_a, busy_b, width_a);
        end
        trigger();
        push_ev(1'b0, 1'b0, 16'd7);
        push_ev(1'b1, 1'b0, 16'd7);
        hold_echo(3, 7);
        settle("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arm_timeout();
        test_meas_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
